// File: rtl/daq_pkg.sv
// Shared types and constants for the ADC frame register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package daq_pkg;

  // Frame assembler states: waiting for a frame start, or mid-frame.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } fsm_state_t;

  // Encoding of mode_i, sampled alongside frame_start_i.
  localparam logic MODE_RREG = 1'b0;
  localparam logic MODE_CONV = 1'b1;

endpackage

// File: rtl/en_register.sv
// Enabled storage register with synchronous active-low clear.
// Latency: q follows d one cycle after an enabled edge.
// Backpressure: none; enable alone decides when d is captured.
//
// Ports: clock_i/reset_ni clock and sync reset, enable capture strobe,
//        d next value, q stored value.
module en_register #(
  parameter int WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/frame_assembler.sv
// Collects byte-serial conversion frames into an assembly buffer; flags RREG bytes.
// Latency: frame_done/frame_data are combinational in the cycle of the final byte.
// Backpressure: none; every valid byte is consumed in the cycle it arrives.
//
// Ports: clock_i/reset_ni clock and sync reset; byte_i/byte_valid_i/frame_start_i/mode_i
//        incoming byte stream; frame_done + frame_data completed frame (final byte
//        merged in); rreg_strobe RREG byte present; frame_abort partial frame discarded.
module frame_assembler
  import daq_pkg::*;
#(
  parameter int REG_WIDTH        = 8,
  parameter int BYTES_PER_SAMPLE = 3,
  parameter int CHANNEL_COUNT    = 4
) (
  input  logic                                clock_i,
  input  logic                                reset_ni,
  input  logic [REG_WIDTH-1:0]                byte_i,
  input  logic                                byte_valid_i,
  input  logic                                frame_start_i,
  input  logic                                mode_i,
  output logic                                frame_done,
  output logic [CHANNEL_COUNT*BYTES_PER_SAMPLE*REG_WIDTH-1:0] frame_data,
  output logic                                rreg_strobe,
  output logic                                frame_abort
);

  localparam int FRAME_BYTES = CHANNEL_COUNT * BYTES_PER_SAMPLE;
  localparam int FRAME_W     = FRAME_BYTES * REG_WIDTH;
  localparam int CNT_W       = $clog2(FRAME_BYTES + 1);

  fsm_state_t         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [FRAME_W-1:0] asm_q, asm_d;
  logic               start;
  logic               conv_start;
  logic               store;
  logic [CNT_W-1:0]   k;
  int                 slot;

  always_comb begin
    start       = byte_valid_i & frame_start_i;
    conv_start  = start & (mode_i == MODE_CONV);
    rreg_strobe = start & (mode_i == MODE_RREG);
    // A start while mid-frame throws the partial frame away, then is
    // handled exactly like a start seen from IDLE.
    frame_abort = start & (state_q == COLLECT);
    store       = conv_start | (byte_valid_i & ~frame_start_i & (state_q == COLLECT));
    k           = start ? '0 : count_q;
    // Samples arrive MSB first, so byte k lands in the top slot of its
    // channel first and walks down towards slot 0 (the LSB byte).
    slot = (int'(k) / BYTES_PER_SAMPLE) * BYTES_PER_SAMPLE
         + (BYTES_PER_SAMPLE - 1) - (int'(k) % BYTES_PER_SAMPLE);

    asm_d      = asm_q;
    frame_done = 1'b0;
    state_d    = state_q;
    count_d    = count_q;

    if (store) begin
      for (int p = 0; p < FRAME_BYTES; p++) begin
        if (p == slot) begin
          asm_d[p*REG_WIDTH +: REG_WIDTH] = byte_i;
        end
      end
      if (k == CNT_W'(FRAME_BYTES - 1)) begin
        frame_done = 1'b1;
        state_d    = IDLE;
        count_d    = '0;
      end else begin
        state_d = COLLECT;
        count_d = k + 1'b1;
      end
    end else if (rreg_strobe) begin
      state_d = IDLE;
      count_d = '0;
    end
  end

  // The final byte is merged before the register, so the top can load the
  // whole frame on the same edge that accepts that byte.
  assign frame_data = asm_d;

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      asm_q   <= asm_d;
    end
  end

endmodule

// File: rtl/adc_frame_regfile.sv
// Assembles ADC read-back bytes into an RREG register and double-buffered sample frames.
// Latency: rreg/error/overrun one cycle after the byte; sample_valid_o one cycle after the final byte.
// Backpressure: valid/ready on samples; a frame completing into a held buffer is dropped (sticky overrun).
//
// Ports: clock_i/reset_ni clock and sync active-low reset; byte_i/byte_valid_i/frame_start_i/mode_i
//        byte stream from the SPI engine; rreg_o/rreg_valid_o last RREG byte and update pulse;
//        sample_o/sample_valid_o/sample_ready_i frame output handshake; overrun_o/clear_overrun_i
//        sticky drop flag; frame_error_o aborted-frame pulse.
module adc_frame_regfile
  import daq_pkg::*;
#(
  parameter int REG_WIDTH        = 8,
  parameter int BYTES_PER_SAMPLE = 3,
  parameter int CHANNEL_COUNT    = 4,
  localparam int SAMPLE_WIDTH    = BYTES_PER_SAMPLE * REG_WIDTH,
  localparam int FRAME_BYTES     = CHANNEL_COUNT * BYTES_PER_SAMPLE
) (
  input  logic                                  clock_i,
  input  logic                                  reset_ni,
  input  logic [REG_WIDTH-1:0]                  byte_i,
  input  logic                                  byte_valid_i,
  input  logic                                  frame_start_i,
  input  logic                                  mode_i,
  output logic [REG_WIDTH-1:0]                  rreg_o,
  output logic                                  rreg_valid_o,
  output logic [CHANNEL_COUNT*SAMPLE_WIDTH-1:0] sample_o,
  output logic                                  sample_valid_o,
  input  logic                                  sample_ready_i,
  output logic                                  overrun_o,
  input  logic                                  clear_overrun_i,
  output logic                                  frame_error_o
);

  logic                              frame_done;
  logic [FRAME_BYTES*REG_WIDTH-1:0]  frame_data;
  logic                              rreg_strobe;
  logic                              frame_abort;
  logic                              buf_free;
  logic                              load;
  logic                              drop;

  frame_assembler #(
    .REG_WIDTH        (REG_WIDTH),
    .BYTES_PER_SAMPLE (BYTES_PER_SAMPLE),
    .CHANNEL_COUNT    (CHANNEL_COUNT)
  ) u_assembler (
    .clock_i       (clock_i),
    .reset_ni      (reset_ni),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .frame_start_i (frame_start_i),
    .mode_i        (mode_i),
    .frame_done    (frame_done),
    .frame_data    (frame_data),
    .rreg_strobe   (rreg_strobe),
    .frame_abort   (frame_abort)
  );

  // The buffer may be overwritten if empty, or if its frame leaves this
  // same cycle; that keeps back-to-back frames bubble-free with ready high.
  assign buf_free = ~sample_valid_o | sample_ready_i;
  assign load     = frame_done & buf_free;
  assign drop     = frame_done & ~buf_free;

  en_register #(
    .WIDTH (CHANNEL_COUNT * SAMPLE_WIDTH)
  ) u_sample_buf (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .enable   (load),
    .d        (frame_data),
    .q        (sample_o)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      sample_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
      rreg_o         <= '0;
      rreg_valid_o   <= 1'b0;
      frame_error_o  <= 1'b0;
    end else begin
      if (load) begin
        sample_valid_o <= 1'b1;
      end else if (sample_valid_o & sample_ready_i) begin
        sample_valid_o <= 1'b0;
      end

      // A drop in the same cycle as a clear request wins, so no overrun
      // event can be silently lost.
      if (drop) begin
        overrun_o <= 1'b1;
      end else if (clear_overrun_i) begin
        overrun_o <= 1'b0;
      end

      if (rreg_strobe) begin
        rreg_o <= byte_i;
      end
      rreg_valid_o  <= rreg_strobe;
      frame_error_o <= frame_abort;
    end
  end

endmodule
